// File: rtl/pio_pkg.sv
// Shared definitions for the pushbutton/switch input port.
//   ADDR_*  : word addresses of the Avalon-MM register map.
//   EDGE_*  : encodings for the EDGE_TYPE parameter of the input controller.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debouncer.
// The filtered output follows sync_in only after sync_in has differed from it
// for DEBOUNCE_CYCLES consecutive clocks; shorter glitches are discarded.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset (filter returns to IDLE_LEVEL)
//   sync_in   already-synchronized input bit
//   filtered  debounced output bit
module pio_debounce_bit #(
  parameter logic        IDLE_LEVEL      = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic filtered
);

  logic [15:0] cnt_q, cnt_d;
  logic        filt_q, filt_d;

  // Counter only runs while the input disagrees with the filtered value; any
  // agreement (including a glitch returning) restarts it from zero.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_in != filt_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        filt_d = sync_in;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= IDLE_LEVEL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/pushbutton_input_controller.sv
// Avalon-MM input port for board pushbuttons/switches.
// Synchronizes WIDTH asynchronous inputs, optionally debounces them, captures
// selected edges into a sticky register and raises a maskable level irq.
// Build option: define PUSHBUTTON_INPUT_DEBOUNCE_EN to insert one
// pio_debounce_bit per input; otherwise the synchronizer output is used as-is.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      zero-wait-state slave write/select
//   in_port                 asynchronous board inputs
//   readdata                combinational read data (zero-extended)
//   irq                     |(EDGECAPTURE & IRQMASK)
module pushbutton_input_controller
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter logic        IDLE_LEVEL      = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IdleVec = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic             wr_en;

  // Upper writedata bits are intentionally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IdleVec;
      sync2_q <= IdleVec;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef PUSHBUTTON_INPUT_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : gen_debounce
    pio_debounce_bit #(
      .IDLE_LEVEL      (IDLE_LEVEL),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .sync_in  (sync2_q[i]),
      .filtered (filtered[i])
    );
  end
`else
  logic [15:0] unused_debounce_cycles;
  assign unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filtered = sync2_q;
`endif

  always_comb begin
    edge_set = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_set = filtered & ~prev_q;
      EDGE_FALL: edge_set = ~filtered & prev_q;
      default:   edge_set = filtered ^ prev_q;
    endcase
  end

  assign wr_en = chipselect & ~write_n;

  // Clear is applied before set so a same-cycle capture keeps the bit high.
  always_comb begin
    edgecap_d = edgecap_q;
    irqmask_d = irqmask_q;
    if (wr_en && address == ADDR_EDGECAP) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= IdleVec;
      edgecap_q <= '0;
      irqmask_q <= '0;
    end else begin
      prev_q    <= filtered;
      edgecap_q <= edgecap_d;
      irqmask_q <= irqmask_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = filtered;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule
